wb_write_queue: RTL
===================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries, a power of two, at least 2.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports aluValid in 1, aluAddr in 5, aluData in 32, aluReady out 1: ALU writeback request channel.
REQ-005 SHALL have ports memValid in 1, memAddr in 5, memData in 32, memReady out 1: load writeback request channel.
REQ-006 SHALL have ports writeAddr out 5, writeData out 32, RegWrite out 1: registered drive of the register file write port.
REQ-007 SHALL have ports readAddr1 in 5, readAddr2 in 5: snooped register file read addresses.
REQ-008 SHALL have ports fwdHit1/fwdHit2 out 1 and fwdData1/fwdData2 out 32: forwarding result per read port.
REQ-009 SHALL have port count out 3: current queue occupancy.

Function
REQ-010 SHALL implement an in-order FIFO of DEPTH entries, each holding {addr[4:0], data[31:0]}.
REQ-011 SHALL transfer a request when Valid and Ready are both high at a rising edge.
REQ-012 SHALL drive aluReady = (count < DEPTH), computed from the occupancy at the start of the cycle.
REQ-013 SHALL drive memReady = (count < DEPTH-1) OR (count < DEPTH AND NOT aluValid).
REQ-014 When both transfers occur in one cycle, SHALL enqueue the ALU entry first and the mem entry second, so the mem entry is younger.
REQ-015 SHALL accept a request whose addr is 0 but SHALL NOT enqueue it; the write to register 0 is discarded.
REQ-016 SHALL pop the head each cycle the queue is non-empty and load it into the output register: writeAddr/writeData take the head values and RegWrite=1 on the following cycle.
REQ-017 SHALL drive RegWrite=0 in any cycle following an edge at which the queue was empty; writeAddr and writeData SHALL hold their last values.
REQ-018 Latency: a request accepted at edge N SHALL appear with RegWrite=1 after edge N+1, if no older entries are queued; the register file commits it at edge N+2.
REQ-019 SHALL update count as count + enqueued - popped, where simultaneous enqueue and pop are both legal; count SHALL never exceed DEPTH.
REQ-020 Forwarding SHALL search the output register (only while RegWrite=1) plus all valid queue entries for an addr equal to readAddrN.
REQ-021 Forwarding SHALL treat the youngest match as winning and drive fwdHitN=1 with fwdDataN equal to that entry's data; fwdHitN and fwdDataN SHALL be combinational.
REQ-022 SHALL drive fwdHitN=0 and fwdDataN=0 when readAddrN=0 or when there is no match.
REQ-023 Wrap-around: the head and tail pointers SHALL wrap modulo DEPTH with no loss or reordering of entries.

Reset
REQ-024 While rst=1, SHALL immediately clear count, the head and tail pointers, RegWrite, writeAddr and writeData to 0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries and any pending output write; no RegWrite pulse SHALL follow the deassertion of reset.
REQ-026 After reset, aluReady and memReady SHALL be 1 and fwdHit1/fwdHit2 SHALL be 0.

Configuration
REQ-027 SHALL compile the forwarding logic of REQ-020 to REQ-022 in only when macro WB_WRITE_QUEUE_FWD_EN is defined.
REQ-028 Without WB_WRITE_QUEUE_FWD_EN, SHALL tie fwdHit1/fwdHit2 to 0 and fwdData1/fwdData2 to 0; all other behaviour SHALL be unchanged.

Verification
REQ-029 Single write: aluValid with addr 1, data 0xabc12345 -> RegWrite=1, writeAddr=1, writeData=0xabc12345 exactly one cycle later; count returns to 0.
REQ-030 R0 drop: aluValid with addr 0, data 0xabc12345 -> aluReady=1, count stays 0, no RegWrite pulse.
REQ-031 Dual issue: ALU (2, 0x30663220) and mem (2, 0x12345678) in the same cycle -> two consecutive RegWrite pulses in ALU-then-mem order; meanwhile readAddr1=2 gives fwdHit1=1 and fwdData1=0x12345678.
REQ-032 Full: fill 4 entries with RegWrite popping -> count reaches 4 at most, aluReady=0 at count 4; with one slot free and both channels valid -> memReady=0 and only the ALU request is accepted.
REQ-033 Reset mid-queue: assert rst with count 3 -> count=0 and RegWrite=0 immediately, with no write after release.
REQ-034 Build without WB_WRITE_QUEUE_FWD_EN and rerun REQ-031 -> fwdHit1=0, with identical write order.

Source files
------------

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: writeback request channels, register file write port, forwarding snoop and occupancy
interface wb_write_queue_if;
    logic        aluValid;
    logic [4:0]  aluAddr;
    logic [31:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memAddr;
    logic [31:0] memData;
    logic        memReady;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        RegWrite;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic        fwdHit1;
    logic        fwdHit2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;
    logic [2:0]  count;
    modport master (
        output aluValid, aluAddr, aluData, memValid, memAddr, memData, readAddr1, readAddr2,
        input  aluReady, memReady, writeAddr, writeData, RegWrite, fwdHit1, fwdHit2, fwdData1, fwdData2, count
    );
    modport slave (
        input  aluValid, aluAddr, aluData, memValid, memAddr, memData, readAddr1, readAddr2,
        output aluReady, memReady, writeAddr, writeData, RegWrite, fwdHit1, fwdHit2, fwdData1, fwdData2, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback queue merging ALU and load results; forwarding built only with WB_WRITE_QUEUE_FWD_EN
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    wb_write_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] depthVal = (AW+1)'(DEPTH);
    localparam logic [AW:0] almostFull = (AW+1)'(DEPTH - 1);
    logic [4:0]    addrMem [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [AW-1:0] head, tail, memSlot;
    logic [AW:0]   occ;
    logic          aluEnq, memEnq, pop;
    assign bus.aluReady = occ < depthVal;
    assign bus.memReady = (occ < almostFull) || (occ < depthVal && !bus.aluValid);
    assign aluEnq = bus.aluValid && bus.aluReady && bus.aluAddr != 5'd0;
    assign memEnq = bus.memValid && bus.memReady && bus.memAddr != 5'd0;
    assign pop = occ != '0;
    assign memSlot = tail + AW'(aluEnq);
    assign bus.count = 3'(occ);
    // ALU entry lands at the tail; a same-cycle load entry goes right behind it
    always_ff @(posedge clk) begin
        if (aluEnq) begin
            addrMem[tail] <= bus.aluAddr;
            dataMem[tail] <= bus.aluData;
        end
        if (memEnq) begin
            addrMem[memSlot] <= bus.memAddr;
            dataMem[memSlot] <= bus.memData;
        end
    end
    // pointers, occupancy and the registered write port; head drains every non-empty cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ <= '0;
            bus.RegWrite <= 1'b0;
            bus.writeAddr <= 5'd0;
            bus.writeData <= 32'd0;
        end else begin
            head <= head + AW'(pop);
            tail <= memSlot + AW'(memEnq);
            occ <= occ + (AW+1)'(aluEnq) + (AW+1)'(memEnq) - (AW+1)'(pop);
            bus.RegWrite <= pop;
            if (pop) begin
                bus.writeAddr <= addrMem[head];
                bus.writeData <= dataMem[head];
            end
        end
    end
`ifdef WB_WRITE_QUEUE_FWD_EN
    logic          hit1, hit2;
    logic [31:0]   data1, data2;
    logic [AW-1:0] idx;
    // scan oldest to youngest (output register, then head onward) so later matches override
    always_comb begin
        hit1 = bus.RegWrite && bus.writeAddr == bus.readAddr1;
        hit2 = bus.RegWrite && bus.writeAddr == bus.readAddr2;
        data1 = hit1 ? bus.writeData : 32'd0;
        data2 = hit2 ? bus.writeData : 32'd0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((AW+1)'(i) < occ && addrMem[idx] == bus.readAddr1) begin
                hit1 = 1'b1;
                data1 = dataMem[idx];
            end
            if ((AW+1)'(i) < occ && addrMem[idx] == bus.readAddr2) begin
                hit2 = 1'b1;
                data2 = dataMem[idx];
            end
        end
        hit1 = hit1 && bus.readAddr1 != 5'd0;
        hit2 = hit2 && bus.readAddr2 != 5'd0;
        data1 = hit1 ? data1 : 32'd0;
        data2 = hit2 ? data2 : 32'd0;
    end
    assign bus.fwdHit1 = hit1;
    assign bus.fwdHit2 = hit2;
    assign bus.fwdData1 = data1;
    assign bus.fwdData2 = data2;
`else
    logic unusedRead;
    assign unusedRead = ^{bus.readAddr1, bus.readAddr2};
    assign bus.fwdHit1 = 1'b0;
    assign bus.fwdHit2 = 1'b0;
    assign bus.fwdData1 = 32'd0;
    assign bus.fwdData2 = 32'd0;
`endif
endmodule
